// File: rtl/priority_encoder_8x3.sv
// priority_encoder_8x3
//   Collects one-bit request lines into a sticky pending register. The
//   highest-priority pending line is encoded to a binary index, and that
//   index is presented over a valid/ready handshake. When a code is
//   accepted, its pending bit is cleared.
//
//   State   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | nothing presented; loads the next code if any bit is pending
//   PRESENT | code/valid held stable until valid && ready
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous reset, active high
//   En       in   1   request capture enable
//   req      in   N   request lines, captured every edge while En=1
//   code     out  W   registered index of the presented line
//   valid    out  1   registered; code is valid
//   ready    in   1   consumer accepts code on valid && ready at an edge
//   pending  out  N   sticky pending register
//   multi    out  1   more than one pending bit set

module priority_encoder_8x3 #(
    parameter int N          = 8,
    parameter int W          = 3,
    parameter int HIGH_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         multi
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_nxt_state;
    logic [W-1:0] r_code;
    logic [W-1:0] w_nxt_code;
    logic         r_valid;
    logic         w_nxt_valid;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_nxt_pending;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_set;
    logic [W-1:0] w_sel;
    logic         w_any;

    // A set and a clear of the same bit in one cycle leaves the bit set,
    // so a request that arrives as its code is accepted is served again.
    always_comb begin
        w_clr         = (r_valid && ready) ? (N'(1) << r_code) : '0;
        w_set         = En ? req : '0;
        w_nxt_pending = (r_pending & ~w_clr) | w_set;
    end

    // The selection looks only at the registered pending bits. With an
    // ascending scan the last hit is the highest index, and with a
    // descending scan the last hit is the lowest index.
    always_comb begin
        w_sel = '0;
        w_any = |r_pending;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (r_pending[i]) w_sel = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r_pending[i]) w_sel = W'(i);
            end
        end
    end

    // In PRESENT the code is not re-selected, so a newer higher-priority
    // request cannot preempt a code that is already presented.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_code  = r_code;
        w_nxt_valid = r_valid;
        case (r_state)
            S_IDLE: begin
                w_nxt_valid = 1'b0;
                if (w_any) begin
                    w_nxt_code  = w_sel;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ready) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_code    <= w_nxt_code;
            r_valid   <= w_nxt_valid;
            r_pending <= w_nxt_pending;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign multi   = (r_pending & (r_pending - N'(1))) != '0;

endmodule
